// File: rtl/lfsr10_gen_if.sv
// Bus bundle for lfsr10_gen: step/load controls, seed, and the
// generator outputs (state, new-value strobe, sequence-wrap strobe).
interface lfsr10_gen_if;
    logic       en;
    logic       load;
    logic [9:0] seed;
    logic [9:0] rnd;
    logic       valid;
    logic       wrap;

    // Driver of the controls / consumer of the generated values
    modport master (
        output en,
        output load,
        output seed,
        input  rnd,
        input  valid,
        input  wrap
    );

    // The LFSR generator itself
    modport slave (
        input  en,
        input  load,
        input  seed,
        output rnd,
        output valid,
        output wrap
    );
endinterface

// File: rtl/lfsr10_gen.sv
// lfsr10_gen: 10-bit Fibonacci LFSR (x^10 + x^7 + 1), period 1023.
// rnd is the raw state; valid strobes the cycle after a load or step.
// Define LFSR10_WRAP_EN to build the start register and step counter
// that drive the wrap strobe; otherwise wrap is tied low.
module lfsr10_gen (
    input  logic          clk,
    input  logic          reset,
    lfsr10_gen_if.slave   bus
);

    logic [9:0] r_q;
    logic       r_valid;
    logic [9:0] w_next;
    logic [9:0] w_load_val;

    // Next-state and seed-sanitising logic (all-zero seed would lock up)
    always_comb begin
        w_next     = {r_q[8:0], r_q[9] ^ r_q[6]};
        w_load_val = (bus.seed == '0) ? 10'h001 : bus.seed;
    end

    // LFSR state and new-value strobe; load takes priority over a step
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q     <= 10'h001;
            r_valid <= 1'b0;
        end else if (bus.load) begin
            r_q     <= w_load_val;
            r_valid <= 1'b1;
        end else if (bus.en) begin
            r_q     <= w_next;
            r_valid <= 1'b1;
        end else begin
            r_valid <= 1'b0;
        end
    end

`ifdef LFSR10_WRAP_EN
    logic [9:0] r_start;
    logic [9:0] r_cnt;
    logic       r_wrap;
    logic       w_wrap_hit;

    // Final step of a full period: counter at 1022 and next state is the start value
    always_comb begin
        w_wrap_hit = (r_cnt == 10'd1022) && (w_next == r_start);
    end

    // Start capture, modulo-1023 step counter and registered wrap strobe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_start <= 10'h001;
            r_cnt   <= '0;
            r_wrap  <= 1'b0;
        end else if (bus.load) begin
            r_start <= w_load_val;
            r_cnt   <= '0;
            r_wrap  <= 1'b0;
        end else if (bus.en) begin
            r_cnt   <= (r_cnt == 10'd1022) ? 10'd0 : r_cnt + 10'd1;
            r_wrap  <= w_wrap_hit;
        end else begin
            r_wrap  <= 1'b0;
        end
    end

    // Drive outputs
    always_comb begin
        bus.rnd   = r_q;
        bus.valid = r_valid;
        bus.wrap  = r_wrap;
    end
`else
    // Drive outputs; wrap detection not built
    always_comb begin
        bus.rnd   = r_q;
        bus.valid = r_valid;
        bus.wrap  = 1'b0;
    end
`endif

endmodule

// File: tb/tb_lfsr10_gen.sv
// Self-checking bench for lfsr10_gen: scoreboard of expected outputs
// pushed on every driven cycle and popped one edge later.
module tb_lfsr10_gen;

    typedef struct {
        logic [9:0] rnd;
        logic       valid;
        logic       wrap;
    } exp_t;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    exp_t sb[$];

    // Bench reference model state
    logic [9:0] m_q;
    logic [9:0] m_start;
    int         m_cnt;

    lfsr10_gen_if bus ();

    lfsr10_gen dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [9:0] ref_next(input logic [9:0] q);
        return {q[8:0], q[9] ^ q[6]};
    endfunction

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q     = 10'h001;
        m_start = 10'h001;
        m_cnt   = 0;
    endtask

    // One clock cycle: drive, predict, push, clock, pop and compare
    task automatic cyc(input logic e, input logic l, input logic [9:0] s, input string tag);
        exp_t x;
        exp_t got;
        bus.en   = e;
        bus.load = l;
        bus.seed = s;
        x.wrap = 1'b0;
        if (!reset) begin
            model_reset();
            x.valid = 1'b0;
        end else if (l) begin
            m_q     = (s == 10'h000) ? 10'h001 : s;
            m_start = m_q;
            m_cnt   = 0;
            x.valid = 1'b1;
        end else if (e) begin
            m_q = ref_next(m_q);
`ifdef LFSR10_WRAP_EN
            x.wrap = (m_cnt == 1022);
`endif
            m_cnt   = (m_cnt == 1022) ? 0 : m_cnt + 1;
            x.valid = 1'b1;
        end else begin
            x.valid = 1'b0;
        end
        x.rnd = m_q;
        sb.push_back(x);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk({tag, ".rnd"},   bus.rnd,          got.rnd);
        chk({tag, ".valid"}, {9'd0, bus.valid}, {9'd0, got.valid});
        chk({tag, ".wrap"},  {9'd0, bus.wrap},  {9'd0, got.wrap});
    endtask

    logic [9:0] seq27 [0:6];
    logic       seen [0:1023];
    logic [9:0] hold_v;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        seq27[0] = 10'h002; seq27[1] = 10'h004; seq27[2] = 10'h008; seq27[3] = 10'h010;
        seq27[4] = 10'h020; seq27[5] = 10'h040; seq27[6] = 10'h081;

        // Asynchronous reset before any clock edge
        reset    = 1'b1;
        bus.en   = 1'b0;
        bus.load = 1'b0;
        bus.seed = '0;
        #1 reset = 1'b0;
        model_reset();
        #2;
        chk("rst.rnd",   bus.rnd,          10'h001);
        chk("rst.valid", {9'd0, bus.valid}, 10'h000);
        chk("rst.wrap",  {9'd0, bus.wrap},  10'h000);
        #9 reset = 1'b1;

        // Seven steps from reset against the fixed table
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, 1'b0, '0, "seq");
            chk("seq.tbl", bus.rnd, seq27[i]);
        end

        // Zero seed substitutes 1; all-ones seed loads directly
        cyc(1'b0, 1'b1, 10'h000, "ld0");
        cyc(1'b0, 1'b1, 10'h3FF, "ld3ff");
        chk("ld3ff.abs", bus.rnd, 10'h3FF);

        // Load wins over step on the same edge
        cyc(1'b1, 1'b1, 10'h155, "ldEn");
        chk("ldEn.abs", bus.rnd, 10'h155);

        // Alternating enable: value changes only after en edges
        for (int i = 0; i < 8; i++) begin
            hold_v = bus.rnd;
            cyc(i[0] == 1'b0, 1'b0, '0, "alt");
            if (i[0] == 1'b1) chk("alt.hold", bus.rnd, hold_v);
        end

        // Reload current value restarts the count; full period from there
        cyc(1'b0, 1'b1, bus.rnd, "reld");
        for (int i = 0; i < 1023; i++) cyc(1'b1, 1'b0, '0, "per2");

        // Reset, then full period: distinct nonzero values, wrap at the end
        cyc(1'b0, 1'b0, '0, "idle");
        reset = 1'b0;
        model_reset();
        #2 reset = 1'b1;
        for (int i = 0; i < 1024; i++) seen[i] = 1'b0;
        for (int i = 0; i < 1023; i++) begin
            cyc(1'b1, 1'b0, '0, "per");
            chk("per.nz",   {9'd0, bus.rnd != 10'h000}, 10'h001);
            chk("per.uniq", {9'd0, seen[bus.rnd]},      10'h000);
            seen[bus.rnd] = 1'b1;
        end
        chk("per.end", bus.rnd, 10'h001);
`ifdef LFSR10_WRAP_EN
        chk("per.wrap", {9'd0, bus.wrap}, 10'h001);
`else
        chk("per.wrap", {9'd0, bus.wrap}, 10'h000);
`endif

        // 100 steps, then reset between edges
        for (int i = 0; i < 100; i++) cyc(1'b1, 1'b0, '0, "pre");
        #2 reset = 1'b0;
        #1;
        chk("mid.rnd",   bus.rnd,          10'h001);
        chk("mid.valid", {9'd0, bus.valid}, 10'h000);
        chk("mid.wrap",  {9'd0, bus.wrap},  10'h000);

        // Reset held across an edge with load and en both active
        cyc(1'b1, 1'b1, 10'h2AA, "rstOvr");
        reset = 1'b1;
        cyc(1'b1, 1'b0, '0, "post");
        chk("post.abs", bus.rnd, 10'h002);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
